// File: rtl/enc_dec_pkg.sv
// Shared SEC-DED definitions for the encode/decode datapath: width codes, field sizes
// and the parity-check matrix columns (parity bit k has column 1<<k).
package enc_dec_pkg;

  typedef enum logic [1:0] {
    CW_SMALL   = 2'b00,
    CW_MEDIUM  = 2'b01,
    CW_LARGE   = 2'b10,
    CW_ILLEGAL = 2'b11
  } cw_width_e;

  localparam int CW_W_SMALL  = 8;
  localparam int D_W_SMALL   = 4;
  localparam int P_W_SMALL   = 4;
  localparam int CW_W_MEDIUM = 16;
  localparam int D_W_MEDIUM  = 11;
  localparam int P_W_MEDIUM  = 5;
  localparam int CW_W_LARGE  = 32;
  localparam int D_W_LARGE   = 26;
  localparam int P_W_LARGE   = 6;

  // Data columns are the odd-weight (>=3) vectors in descending order, giving Hsiao SEC-DED.
  localparam logic [5:0] H_SMALL [0:7] = '{
    6'd1, 6'd2, 6'd4, 6'd8,
    6'd14, 6'd13, 6'd11, 6'd7
  };

  localparam logic [5:0] H_MEDIUM [0:15] = '{
    6'd1, 6'd2, 6'd4, 6'd8, 6'd16,
    6'd31, 6'd28, 6'd26, 6'd25, 6'd22, 6'd21,
    6'd19, 6'd14, 6'd13, 6'd11, 6'd7
  };

  localparam logic [5:0] H_LARGE [0:31] = '{
    6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32,
    6'd62, 6'd61, 6'd59, 6'd56, 6'd55, 6'd52, 6'd50, 6'd49, 6'd47, 6'd44,
    6'd42, 6'd41, 6'd38, 6'd37, 6'd35, 6'd31, 6'd28, 6'd26, 6'd25, 6'd22,
    6'd21, 6'd19, 6'd14, 6'd13, 6'd11, 6'd7
  };

  function automatic logic [31:0] cw_mask(cw_width_e w);
    case (w)
      CW_SMALL:  return 32'h0000_00FF;
      CW_MEDIUM: return 32'h0000_FFFF;
      CW_LARGE:  return 32'hFFFF_FFFF;
      default:   return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome: XOR of the H columns selected by the set codeword bits.
module hamming_syndrome
  import enc_dec_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_codeword,
  input  cw_width_e             i_width,
  output logic [5:0]            o_syndrome
);

  always_comb begin
    o_syndrome = 6'd0;
    case (i_width)
      CW_SMALL: begin
        for (int k = 0; k < CW_W_SMALL; k++)
          if (i_codeword[k]) o_syndrome = o_syndrome ^ H_SMALL[k];
      end
      CW_MEDIUM: begin
        for (int k = 0; k < CW_W_MEDIUM; k++)
          if (i_codeword[k]) o_syndrome = o_syndrome ^ H_MEDIUM[k];
      end
      CW_LARGE: begin
        for (int k = 0; k < CW_W_LARGE; k++)
          if (i_codeword[k]) o_syndrome = o_syndrome ^ H_LARGE[k];
      end
      default: o_syndrome = 6'd0;
    endcase
  end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage SEC-DED decoder (syndrome, then correct/classify) with valid/ready on both sides.
// Optional error counters are enabled by defining HAMMING_DEC_ERR_CNT_EN.
module hamming_decoder
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           CODEWORD_WIDTH,
  input  logic [AMBA_WORD-1:0] DATA_IN,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [AMBA_WORD-1:0] DATA_OUT,
  output logic [1:0]           NUM_OF_ERR,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef HAMMING_DEC_ERR_CNT_EN
  ,
  output logic [15:0]          corr_cnt,
  output logic [15:0]          uncorr_cnt
`endif
);

  logic                  w_adv;
  cw_width_e             w_in_width;
  logic [DATA_WIDTH-1:0] w_cw_masked;
  logic [5:0]            w_syn;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_cw;
  cw_width_e             r_s1_width;
  logic [5:0]            r_s1_syn;

  logic                  r_out_valid;
  logic [AMBA_WORD-1:0]  r_data_out;
  logic [1:0]            r_num_err;

  logic [DATA_WIDTH-1:0] w_fixed;
  logic                  w_hit;
  int                    w_pbits;
  logic [DATA_WIDTH-1:0] w_dmask;
  logic [AMBA_WORD-1:0]  w_data;
  logic [1:0]            w_nerr;

  assign w_adv       = !r_out_valid || out_ready;
  assign in_ready    = w_adv;
  assign w_in_width  = cw_width_e'(CODEWORD_WIDTH);
  assign w_cw_masked = DATA_IN[DATA_WIDTH-1:0] & DATA_WIDTH'(cw_mask(w_in_width));

  hamming_syndrome #(.DATA_WIDTH(DATA_WIDTH)) u_syndrome (
    .i_codeword (w_cw_masked),
    .i_width    (w_in_width),
    .o_syndrome (w_syn)
  );

  // Stage 2: a syndrome matching a column flips that bit; columns are distinct and nonzero.
  always_comb begin
    w_fixed = r_s1_cw;
    w_hit   = 1'b0;
    w_pbits = 0;
    w_dmask = '0;
    case (r_s1_width)
      CW_SMALL: begin
        w_pbits = P_W_SMALL;
        w_dmask = DATA_WIDTH'(32'h0000_000F);
        for (int k = 0; k < CW_W_SMALL; k++)
          if (H_SMALL[k] == r_s1_syn) begin
            w_fixed[k] = ~r_s1_cw[k];
            w_hit      = 1'b1;
          end
      end
      CW_MEDIUM: begin
        w_pbits = P_W_MEDIUM;
        w_dmask = DATA_WIDTH'(32'h0000_07FF);
        for (int k = 0; k < CW_W_MEDIUM; k++)
          if (H_MEDIUM[k] == r_s1_syn) begin
            w_fixed[k] = ~r_s1_cw[k];
            w_hit      = 1'b1;
          end
      end
      CW_LARGE: begin
        w_pbits = P_W_LARGE;
        w_dmask = DATA_WIDTH'(32'h03FF_FFFF);
        for (int k = 0; k < CW_W_LARGE; k++)
          if (H_LARGE[k] == r_s1_syn) begin
            w_fixed[k] = ~r_s1_cw[k];
            w_hit      = 1'b1;
          end
      end
      default: begin
        w_pbits = 0;
        w_dmask = '0;
      end
    endcase

    w_data = AMBA_WORD'((w_fixed >> w_pbits) & w_dmask);
    if (r_s1_width == CW_ILLEGAL) w_nerr = 2'd2;
    else if (r_s1_syn == 6'd0)    w_nerr = 2'd0;
    else if (w_hit)               w_nerr = 2'd1;
    else                          w_nerr = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_cw     <= '0;
      r_s1_width  <= CW_SMALL;
      r_s1_syn    <= 6'd0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
      r_num_err   <= 2'd0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw    <= w_cw_masked;
        r_s1_width <= w_in_width;
        r_s1_syn   <= w_syn;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_out <= w_data;
        r_num_err  <= w_nerr;
      end
    end
  end

  assign DATA_OUT   = r_data_out;
  assign NUM_OF_ERR = r_num_err;
  assign out_valid  = r_out_valid;

`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [15:0] r_corr_cnt;
  logic [15:0] r_uncorr_cnt;
  logic        w_retire;

  assign w_retire = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_corr_cnt   <= 16'd0;
      r_uncorr_cnt <= 16'd0;
    end else if (w_retire) begin
      if (r_num_err == 2'd1 && r_corr_cnt != 16'hFFFF)
        r_corr_cnt <= r_corr_cnt + 16'd1;
      if (r_num_err == 2'd2 && r_uncorr_cnt != 16'hFFFF)
        r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
    end
  end

  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: a reference model built from the H-matrix
// construction rule, an output scoreboard checked every cycle, and literal pins.
`timescale 1ns/1ps
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cw_width;
  logic [31:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic [1:0]  num_err;
  logic        out_valid;
  logic        out_ready;
`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [15:0] corr_cnt;
  logic [15:0] uncorr_cnt;
  int          m_corr = 0;
  int          m_uncorr = 0;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  nerr;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hamming_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .CODEWORD_WIDTH (cw_width),
    .DATA_IN        (data_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .DATA_OUT       (data_out),
    .NUM_OF_ERR     (num_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
`ifdef HAMMING_DEC_ERR_CNT_EN
    ,
    .corr_cnt       (corr_cnt),
    .uncorr_cnt     (uncorr_cnt)
`endif
  );

  // ---------------- reference model ----------------
  function automatic int pbits(logic [1:0] w);
    return (w == 2'd0) ? 4 : (w == 2'd1) ? 5 : 6;
  endfunction

  function automatic int nbits(logic [1:0] w);
    return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
  endfunction

  // Column k: unit vector for parity bits, else the next odd-weight (>=3) value counting down.
  function automatic logic [5:0] hcol(logic [1:0] w, int k);
    int p;
    int idx;
    p = pbits(w);
    if (k < p) return 6'(1 << k);
    idx = p;
    for (int v = (1 << p) - 1; v > 0; v--) begin
      if ($countones(v) >= 3 && ($countones(v) % 2) == 1) begin
        if (idx == k) return 6'(v);
        idx++;
      end
    end
    return 6'd0;
  endfunction

  function automatic logic [5:0] syn_of(logic [1:0] w, logic [31:0] cw);
    logic [5:0] s;
    s = 6'd0;
    for (int k = 0; k < nbits(w); k++)
      if (cw[k]) s = s ^ hcol(w, k);
    return s;
  endfunction

  function automatic logic [31:0] encode(logic [1:0] w, logic [31:0] d);
    logic [63:0] cw;
    int p;
    p = pbits(w);
    cw = ({32'd0, d} & ((64'd1 << (nbits(w) - p)) - 64'd1)) << p;
    return cw[31:0] | 32'(syn_of(w, cw[31:0]));
  endfunction

  function automatic exp_t model(logic [1:0] w, logic [31:0] din);
    exp_t        e;
    logic [63:0] cw;
    logic [5:0]  s;
    int          p;
    int          n;
    e.data = 32'd0;
    e.nerr = 2'd2;
    if (w == 2'b11) return e;
    p  = pbits(w);
    n  = nbits(w);
    cw = {32'd0, din} & ((64'd1 << n) - 64'd1);
    s  = syn_of(w, cw[31:0]);
    if (s == 6'd0) e.nerr = 2'd0;
    else
      for (int k = 0; k < n; k++)
        if (hcol(w, k) == s) begin
          cw[k]  = ~cw[k];
          e.nerr = 2'd1;
        end
    e.data = 32'((cw >> p) & ((64'd1 << (n - p)) - 64'd1));
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        stalled_prev = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_nerr;

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        exp_q.delete();
        stalled_prev = 1'b0;
`ifdef HAMMING_DEC_ERR_CNT_EN
        m_corr   = 0;
        m_uncorr = 0;
`endif
      end else if (rst === 1'b0) begin
        check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
        if (stalled_prev) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data", data_out, prev_data);
          check("stall_nerr", 32'(num_err), 32'(prev_nerr));
        end
`ifdef HAMMING_DEC_ERR_CNT_EN
        check("corr_cnt", 32'(corr_cnt), 32'(m_corr));
        check("uncorr_cnt", 32'(uncorr_cnt), 32'(m_uncorr));
`endif
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            check("data_out", data_out, exp_q[0].data);
            check("num_of_err", 32'(num_err), 32'(exp_q[0].nerr));
            if (out_ready) begin
`ifdef HAMMING_DEC_ERR_CNT_EN
              if (exp_q[0].nerr == 2'd1 && m_corr < 65535) m_corr++;
              if (exp_q[0].nerr == 2'd2 && m_uncorr < 65535) m_uncorr++;
`endif
              void'(exp_q.pop_front());
            end
          end
        end
        stalled_prev = out_valid && !out_ready;
        prev_data    = data_out;
        prev_nerr    = num_err;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the acceptance edge.
  task automatic send(logic [1:0] w, logic [31:0] d, bit pin,
                      logic [31:0] exp_d, logic [1:0] exp_n);
    exp_t e;
    int   budget;
    bit   done;
    budget   = 50;
    done     = 1'b0;
    e        = model(w, d);
    if (pin) begin
      check("pin_data", e.data, exp_d);
      check("pin_nerr", 32'(e.nerr), 32'(exp_n));
    end
    cw_width = w;
    data_in  = d;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end else begin
        budget--;
        if (budget == 0) begin
          check("accept_timeout", 32'(in_ready), 32'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m1;
    logic [31:0] l1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    cw_width  = 2'd0;
    data_in   = 32'd0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_num_err", 32'(num_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: accepted word appears two cycles after acceptance.
    send(2'd0, 32'h0000_00AA, 1'b1, 32'hA, 2'd0);
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Directed vectors streamed back to back, each pinned by a hand-computed result.
    m1 = encode(2'd1, 32'h5A5);
    l1 = encode(2'd2, 32'h2ABCDEF);
    send(2'd0, 32'h0000_00AB, 1'b1, 32'hA, 2'd1);
    send(2'd0, 32'h0000_002A, 1'b1, 32'hA, 2'd1);
    send(2'd0, 32'h0000_00A9, 1'b1, 32'hA, 2'd2);
    send(2'd0, 32'hFFFF_FFAA, 1'b1, 32'hA, 2'd0);
    send(2'd2, 32'h0010_0000, 1'b1, 32'h0, 2'd1);
    send(2'd2, 32'h0010_0008, 1'b1, 32'h4000, 2'd2);
    send(2'd3, 32'h1234_5678, 1'b1, 32'h0, 2'd2);
    send(2'd1, m1, 1'b1, 32'h5A5, 2'd0);
    send(2'd1, m1 ^ 32'h0000_0004, 1'b1, 32'h5A5, 2'd1);
    send(2'd1, m1 ^ 32'h0000_0300, 1'b1, 32'h5A5 ^ 32'h18, 2'd2);
    send(2'd2, l1, 1'b1, 32'h2ABCDEF, 2'd0);
    send(2'd2, l1 ^ 32'h8000_0000, 1'b1, 32'h2ABCDEF, 2'd1);
    drain();

    // Back-pressure mid-stream with mixed widths.
    fork
      begin
        send(2'd0, 32'h0000_00AB, 1'b0, 32'h0, 2'd0);
        send(2'd1, encode(2'd1, 32'h123) ^ 32'h80, 1'b0, 32'h0, 2'd0);
        send(2'd2, encode(2'd2, 32'h3FF_FFFF), 1'b0, 32'h0, 2'd0);
        send(2'd3, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'd0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with words in flight, then a clean decode.
    send(2'd0, 32'h0000_00AA, 1'b0, 32'h0, 2'd0);
    send(2'd1, m1, 1'b0, 32'h0, 2'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    send(2'd1, m1, 1'b1, 32'h5A5, 2'd0);
    drain();

`ifdef HAMMING_DEC_ERR_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(2'd0, 32'h0000_00AB, 1'b0, 32'h0, 2'd0);
    send(2'd0, 32'h0000_002A, 1'b0, 32'h0, 2'd0);
    send(2'd2, 32'h0010_0000, 1'b0, 32'h0, 2'd0);
    send(2'd0, 32'h0000_00A9, 1'b0, 32'h0, 2'd0);
    send(2'd3, 32'h0000_0000, 1'b0, 32'h0, 2'd0);
    drain();
    @(negedge clk);
    check("cnt_corr_3", 32'(corr_cnt), 32'd3);
    check("cnt_uncorr_2", 32'(uncorr_cnt), 32'd2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 65540; i++) send(2'd3, 32'(i), 1'b0, 32'h0, 2'd0);
    drain();
    @(negedge clk);
    check("cnt_uncorr_sat", 32'(uncorr_cnt), 32'h0000_FFFF);
    check("cnt_corr_hold", 32'(corr_cnt), 32'd3);
    @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
